// File: rtl/adventure_player_pkg.sv
// Shared types for the route player: direction encoding, FSM states, move decode.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package adventure_player_pkg;

    typedef enum logic [1:0] {
        DIR_N = 2'b00,
        DIR_S = 2'b01,
        DIR_E = 2'b10,
        DIR_W = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRST   = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Move command packed as {n, s, e, w}
    function automatic logic [3:0] dir_to_nsew(input dir_t d);
        logic [3:0] v;
        v = 4'b0000;
        case (d)
            DIR_N: v = 4'b1000;
            DIR_S: v = 4'b0100;
            DIR_E: v = 4'b0010;
            DIR_W: v = 4'b0001;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/adventure_player_if.sv
// Bundle of the player's route-load, control, game-side and result signals.
// Latency: none (wiring only).
// Backpressure: load_valid/load_ready handshake on route entry writes.
interface adventure_player_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          load_valid;
    logic [1:0]    load_dir;
    logic          load_ready;
    logic          start;
    logic          clear;
    logic          game_rst;
    logic          n;
    logic          s;
    logic          e;
    logic          w;
    logic          win;
    logic          die;
    logic          busy;
    logic          done;
    logic          success;
    logic          fail;
    logic          stuck;
    logic [CW-1:0] step_count;

    // Host / game side
    modport master (
        output load_valid, load_dir, start, clear, win, die,
        input  load_ready, game_rst, n, s, e, w, busy, done,
               success, fail, stuck, step_count
    );

    // Player side
    modport slave (
        input  load_valid, load_dir, start, clear, win, die,
        output load_ready, game_rst, n, s, e, w, busy, done,
               success, fail, stuck, step_count
    );

endinterface

// File: rtl/adventure_player_route_store.sv
// Route storage: DEPTH x 2-bit direction array with write pointer and entry count.
// Latency: write lands on the next edge; read is combinational from the index.
// Backpressure: o_full high blocks further writes, which are dropped silently.
module route_store
    import adventure_player_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_clr,
    input  logic          i_wr_en,
    input  dir_t          i_wr_dir,
    input  logic [AW-1:0] i_rd_idx,
    output dir_t          o_rd_dir,
    output logic [CW-1:0] o_count,
    output logic          o_full
);

    dir_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_wr_fire;

    assign o_full    = (r_count == CW'(DEPTH));
    assign w_wr_fire = i_wr_en && !i_clr && !o_full;
    assign o_rd_dir  = r_mem[i_rd_idx];
    assign o_count   = r_count;

    // Array contents need no reset: the count alone says what is valid
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr] <= i_wr_dir;
        end
    end

    // Pointer and count: cleared by reset or clear, bumped on each accepted write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_wr_fire) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_count  <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/adventure_player.sv
// Replays a stored route into the game as one-hot moves and reports win/die/stuck.
// Latency: game_rst 1 cycle after start, then one move per cycle, then SETTLE_CYCLES wait.
// Backpressure: load_ready low while running or full. Optional PLAYER_IDLE_GAP_EN adds an idle cycle after each move.
module adventure_player
    import adventure_player_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int SETTLE_CYCLES = 2     // must be >= 1
) (
    input  logic               clk,
    input  logic               reset_n,
    adventure_player_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t        r_state;
    logic [CW-1:0] r_idx;
    logic [CW-1:0] r_step_count;
    logic [SW-1:0] r_settle;
    logic [3:0]    r_nsew;
    logic          r_game_rst;
    logic          r_busy;
    logic          r_done;
    logic          r_success;
    logic          r_fail;
    logic          r_stuck;
`ifdef PLAYER_IDLE_GAP_EN
    logic          r_gap;       // 1 while the current RUN cycle is an idle gap
`endif

    logic          w_load_ready;
    logic          w_wr_en;
    logic          w_start_ok;
    logic          w_more;
    logic          w_full;
    logic [CW-1:0] w_count;
    dir_t          w_rd_dir;

    assign w_load_ready = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && !w_full;
    assign w_wr_en      = bus.load_valid && w_load_ready && !bus.clear;
    assign w_start_ok   = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE))
                          && (w_count != '0);
    assign w_more       = (r_idx < w_count);

    route_store #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .CW    (CW)
    ) u_route_store (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clr    (bus.clear),
        .i_wr_en  (w_wr_en),
        .i_wr_dir (dir_t'(bus.load_dir)),
        .i_rd_idx (r_idx[AW-1:0]),
        .o_rd_dir (w_rd_dir),
        .o_count  (w_count),
        .o_full   (w_full)
    );

    // Player FSM with all result/move outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_step_count <= '0;
            r_settle     <= '0;
            r_nsew       <= '0;
            r_game_rst   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_success    <= 1'b0;
            r_fail       <= 1'b0;
            r_stuck      <= 1'b0;
`ifdef PLAYER_IDLE_GAP_EN
            r_gap        <= 1'b0;
`endif
        end else if (bus.clear) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_step_count <= '0;
            r_settle     <= '0;
            r_nsew       <= '0;
            r_game_rst   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_success    <= 1'b0;
            r_fail       <= 1'b0;
            r_stuck      <= 1'b0;
        end else begin
            r_game_rst <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_state      <= ST_GRST;
                        r_game_rst   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_success    <= 1'b0;
                        r_fail       <= 1'b0;
                        r_stuck      <= 1'b0;
                        r_step_count <= '0;
                        r_idx        <= '0;
                    end
                end
                // Game is held in reset this cycle; outcome flags are stale and ignored
                ST_GRST: begin
                    r_state      <= ST_RUN;
                    r_nsew       <= dir_to_nsew(w_rd_dir);
                    r_idx        <= r_idx + 1'b1;
                    r_step_count <= r_step_count + 1'b1;
`ifdef PLAYER_IDLE_GAP_EN
                    r_gap        <= 1'b0;
`endif
                end
                ST_RUN: begin
                    if (bus.die) begin
                        r_state <= ST_DONE;
                        r_fail  <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_nsew  <= '0;
                    end else if (bus.win) begin
                        r_state   <= ST_DONE;
                        r_success <= 1'b1;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_nsew    <= '0;
`ifdef PLAYER_IDLE_GAP_EN
                    end else if (!r_gap) begin
                        r_nsew <= '0;
                        r_gap  <= 1'b1;
`endif
                    end else if (w_more) begin
                        r_nsew       <= dir_to_nsew(w_rd_dir);
                        r_idx        <= r_idx + 1'b1;
                        r_step_count <= r_step_count + 1'b1;
`ifdef PLAYER_IDLE_GAP_EN
                        r_gap        <= 1'b0;
`endif
                    end else begin
                        r_state  <= ST_SETTLE;
                        r_nsew   <= '0;
                        r_settle <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (bus.die) begin
                        r_state <= ST_DONE;
                        r_fail  <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (bus.win) begin
                        r_state   <= ST_DONE;
                        r_success <= 1'b1;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                    end else if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
                        r_state <= ST_DONE;
                        r_stuck <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_nsew  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load_ready = w_load_ready;
    assign bus.game_rst   = r_game_rst;
    assign bus.n          = r_nsew[3];
    assign bus.s          = r_nsew[2];
    assign bus.e          = r_nsew[1];
    assign bus.w          = r_nsew[0];
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.success    = r_success;
    assign bus.fail       = r_fail;
    assign bus.stuck      = r_stuck;
    assign bus.step_count = r_step_count;

endmodule

// File: doc/adventure_player.md
ADVENTURE_PLAYER -- requirements
Module: adventure_player

Interface
REQ-001 Parameter DEPTH, default 16: maximum route length in steps.
REQ-002 Parameter SETTLE_CYCLES, default 2: post-route cycles to wait for an outcome.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 load_valid  in  1  route-entry write strobe.
REQ-006 load_dir  in  2  route entry: 00=N, 01=S, 10=E, 11=W.
REQ-007 load_ready  out  1  route entry accepted this cycle when load_valid is also high.
REQ-008 start  in  1  begin a run of the stored route.
REQ-009 clear  in  1  empty the route and return to IDLE.
REQ-010 game_rst  out  1  active-high reset pulse to the game.
REQ-011 n, s, e, w  out  1 each  one-hot move command to the game; all zero when not stepping.
REQ-012 win, die  in  1 each  game outcome flags.
REQ-013 busy  out  1  run in progress.
REQ-014 done, success, fail, stuck  out  1 each  run result, held until the next start or clear.
REQ-015 step_count  out  $clog2(DEPTH)+1  directions issued in the current or last run.

Function
REQ-016 The FSM SHALL have states IDLE, GRST, RUN, SETTLE and DONE.
REQ-017 load_ready SHALL be 1 only in IDLE or DONE with fewer than DEPTH stored entries; a write when full SHALL be dropped with no side effect.
REQ-018 start in IDLE or DONE with at least one stored entry SHALL go to GRST, clear the result flags and step_count, and pulse game_rst for exactly 1 cycle.
REQ-019 start with an empty route SHALL be ignored; start while busy SHALL be ignored.
REQ-020 GRST SHALL go to RUN on the next cycle.
REQ-021 RUN SHALL drive one route entry per cycle, one-hot, in load order, incrementing step_count per entry.
REQ-022 In RUN and SETTLE, die=1 SHALL go to DONE with fail=1; otherwise win=1 SHALL go to DONE with success=1; die takes priority when both are 1.
REQ-023 After the last entry is issued, the FSM SHALL enter SETTLE with n/s/e/w all 0 and wait SETTLE_CYCLES cycles for win or die.
REQ-024 If SETTLE expires with no outcome, the FSM SHALL go to DONE with stuck=1.
REQ-025 busy SHALL be 1 in GRST, RUN and SETTLE; done SHALL be 1 in DONE.
REQ-026 The stored route SHALL be preserved across runs, so a start from DONE replays it.
REQ-027 clear SHALL take priority over start, abort any run, zero the entry count and drive n/s/e/w to 0 the next cycle.
REQ-028 win and die SHALL be ignored in IDLE, GRST and DONE.

Reset
REQ-029 While reset_n=0: state IDLE, entry count 0, step_count 0, all outputs 0 except load_ready=1.
REQ-030 Reset asserted mid-run SHALL discard the run and the route immediately, without waiting for a clock edge.

Configuration
REQ-031 With PLAYER_IDLE_GAP_EN defined, RUN SHALL insert one cycle with n/s/e/w all 0 after every issued entry; win and die SHALL still be checked in gap cycles.
REQ-032 Without PLAYER_IDLE_GAP_EN, entries SHALL be issued back-to-back.

Structure
REQ-033 A shared package SHALL hold the direction encoding typedef, the player state typedef, and a function that maps a direction to its n/s/e/w one-hot value.
REQ-034 The route storage (DEPTH x 2-bit array with write pointer and count) SHALL be a sub-module named route_store.

Verification
REQ-035 Route E,S,W,E,E connected to the adventure game -> success=1, step_count=5, done=1, fail=0.
REQ-036 Route E,S,E -> fail=1 within SETTLE_CYCLES cycles of the last step, success=0.
REQ-037 Route E only -> stuck=1 after SETTLE_CYCLES cycles; n/s/e/w are 0 throughout SETTLE.
REQ-038 17 writes with DEPTH=16 -> load_ready=0 after the 16th write, 17th entry not stored, replay issues 16 steps.
REQ-039 win=1 and die=1 together in RUN -> fail=1, success=0.
REQ-040 reset_n driven low mid-RUN -> all outputs 0 except load_ready=1 without waiting for a clock edge, and a following start with an empty route is ignored.
